// File: rtl/proc_pkg.sv
// Shared constants for the bus-processor control path: opcodes, time-slot
// encoding and default bus widths.
package proc_pkg;

    localparam int DIN_W_DEFAULT = 16;
    localparam int IR_W_DEFAULT  = 9;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_e;

endpackage

// File: rtl/dec3to8.sv
// Register-index decoder: 3-bit index to one-hot select, index 0 maps to the
// MSB so that bit7 is R0 and bit0 is R7.
module dec3to8 (
    input  logic [2:0] idx,
    output logic [7:0] onehot
);

    assign onehot = 8'h80 >> idx;

endmodule

// File: rtl/proc_control_unit.sv
// Instruction sequencer: captures {III,XXX,YYY} from DIN on Run and walks it
// through T0..T3, driving bus selects and register enables for each slot.
module proc_control_unit
    import proc_pkg::*;
#(
    parameter int DIN_W = DIN_W_DEFAULT,
    parameter int IR_W  = IR_W_DEFAULT
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Run,
    input  logic [DIN_W-1:0] DIN,
    output logic [7:0]       Rout,
    output logic [7:0]       Rin,
    output logic             Gout,
    output logic             DINout,
    output logic             Ain,
    output logic             Gin,
    output logic             AddSub,
    output logic             Done,
    output logic [1:0]       Tstep,
    output logic [IR_W-1:0]  IR
);

    tstep_e          tstep_q, tstep_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic [2:0]      op;
    logic [7:0]      x_oh, y_oh;
    logic            unused_din;

    // Low DIN bits carry immediate data for the datapath, not instruction bits.
    assign unused_din = ^DIN[DIN_W-IR_W-1:0];

    assign op    = ir_q[8:6];
    assign Tstep = tstep_q;
    assign IR    = ir_q;

    dec3to8 u_dec_x (.idx(ir_q[5:3]), .onehot(x_oh));
    dec3to8 u_dec_y (.idx(ir_q[2:0]), .onehot(y_oh));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            tstep_q <= T0;
            ir_q    <= '0;
        end else begin
            tstep_q <= tstep_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        tstep_d = tstep_q;
        ir_d    = ir_q;
        case (tstep_q)
            T0: begin
                if (Run) begin
                    ir_d    = DIN[DIN_W-1 -: IR_W];
                    tstep_d = T1;
                end
            end
            T1:      tstep_d = (op == OP_ADD || op == OP_SUB) ? T2 : T0;
            T2:      tstep_d = T3;
            default: tstep_d = T0;
        endcase
    end

    // Outputs depend only on the registered slot and instruction, never on Run.
    always_comb begin
        Rout   = '0;
        Rin    = '0;
        Gout   = 1'b0;
        DINout = 1'b0;
        Ain    = 1'b0;
        Gin    = 1'b0;
        AddSub = 1'b0;
        Done   = 1'b0;
        case (tstep_q)
            T1: begin
                case (op)
                    OP_MV: begin
                        Rout = y_oh;
                        Rin  = x_oh;
                        Done = 1'b1;
                    end
                    OP_MVI: begin
                        DINout = 1'b1;
                        Rin    = x_oh;
                        Done   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        Rout = x_oh;
                        Ain  = 1'b1;
                    end
                    default: Done = 1'b1;
                endcase
            end
            T2: begin
                Rout   = y_oh;
                Gin    = 1'b1;
                AddSub = op[0];
            end
            T3: begin
                Gout = 1'b1;
                Rin  = x_oh;
                Done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
